// File: rtl/md_issue_if.sv
// Handshake bundle between the E-stage, the md_issue controller and the multiply/divide unit.
// The slave modport is the controller; the master modport is the pipeline/unit side.
interface md_issue_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [1:0]  req_wsrc;
  logic        req_rd;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_busy;
  logic        Start;
  logic [2:0]  opsrc;
  logic [1:0]  wsrc;
  logic [31:0] D1;
  logic [31:0] D2;
  logic        stall;
  logic        illegal_op;

  modport master (
    output req_valid, req_op, req_wsrc, req_rd, rs_val, rt_val, md_busy,
    input  Start, opsrc, wsrc, D1, D2, stall, illegal_op
  );

  modport slave (
    input  req_valid, req_op, req_wsrc, req_rd, rs_val, rt_val, md_busy,
    output Start, opsrc, wsrc, D1, D2, stall, illegal_op
  );
endinterface

// File: rtl/md_issue.sv
// Issue controller for the multiply/divide unit: accepts E-stage mult/div/mthi/mtlo, stalls the pipe.
// Optional feature macro: MD_MADD_EN (accept req_op=5 as madd).
//
// Handshake: a request is taken in IDLE when req_valid=1, the encoding is legal and md_busy=0;
// stall stays high while a touching request cannot be taken, and the requester holds its inputs.
module md_issue (
  input  logic       Clk,
  input  logic       Reset,
  md_issue_if.slave  bus,
  output logic [1:0] state
);

`ifdef MD_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, WRITE = 2'd3} state_t;

  state_t      st;
  logic        start_q;
  logic [2:0]  opsrc_q;
  logic [1:0]  wsrc_q;
  logic [31:0] d1_q;
  logic [31:0] d2_q;
  logic        illegal_q;

  logic op_ok;
  logic touch;
  logic in_idle;
  logic accept_op;
  logic accept_wr;
  logic reject;
  logic flag;

  always_comb begin
    op_ok = 1'b0;
    case (bus.req_op)
      3'd1, 3'd2, 3'd3, 3'd4: op_ok = 1'b1;
      3'd5:                   op_ok = MADD_EN;
      default:                op_ok = 1'b0;
    endcase
    touch     = (bus.req_op != 3'd0) || (bus.req_wsrc != 2'd0) || bus.req_rd;
    in_idle   = (st == IDLE);
    accept_op = in_idle && bus.req_valid && op_ok && !bus.md_busy;
    accept_wr = in_idle && bus.req_valid && (bus.req_op == 3'd0) &&
                ((bus.req_wsrc == 2'd1) || (bus.req_wsrc == 2'd2)) && !bus.md_busy;
    // A rejected encoding never freezes the pipe; an op+wsrc collision is flagged but op still issues.
    reject    = ((bus.req_op != 3'd0) && !op_ok) ||
                ((bus.req_op == 3'd0) && (bus.req_wsrc == 2'd3));
    flag      = in_idle && bus.req_valid &&
                (reject || ((bus.req_op != 3'd0) && (bus.req_wsrc != 2'd0)));
  end

  assign bus.stall = bus.req_valid && touch &&
                     (!in_idle || (bus.md_busy && !reject) || accept_op || accept_wr);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      st        <= IDLE;
      start_q   <= 1'b0;
      opsrc_q   <= 3'd0;
      wsrc_q    <= 2'd0;
      d1_q      <= 32'd0;
      d2_q      <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      start_q   <= accept_op;
      wsrc_q    <= accept_wr ? bus.req_wsrc : 2'd0;
      illegal_q <= flag;
      if (accept_op) begin
        opsrc_q <= bus.req_op;
        d1_q    <= bus.rs_val;
        d2_q    <= bus.rt_val;
      end else if (accept_wr) begin
        d1_q    <= bus.rs_val;
      end
      case (st)
        IDLE: begin
          if (accept_op)      st <= ISSUE;
          else if (accept_wr) st <= WRITE;
        end
        ISSUE:   st <= WAIT;
        WAIT:    if (!bus.md_busy) st <= IDLE;
        WRITE:   st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.Start      = start_q;
  assign bus.opsrc      = opsrc_q;
  assign bus.wsrc       = wsrc_q;
  assign bus.D1         = d1_q;
  assign bus.D2         = d2_q;
  assign bus.illegal_op = illegal_q;
  assign state          = st;

endmodule

// File: tb/tb_md_issue.sv
// Directed bench for md_issue with a simple busy-counter model of the multiply/divide unit.
module tb_md_issue;
  logic       clk;
  logic       rst;
  logic [1:0] state;
  int         checks;
  int         errors;
  int         busy_len;
  int         busy_cnt;

  md_issue_if bus();

  md_issue dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave),
    .state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unit model: Busy rises at the edge that samples Start and stays high busy_len cycles.
  always @(posedge clk) begin
    if (rst)                busy_cnt <= 0;
    else if (bus.Start)     busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.md_busy = (busy_cnt != 0);

  task step;
    @(posedge clk);
    #1;
  endtask

  task idle_inputs;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_wsrc  = 2'd0;
    bus.req_rd    = 1'b0;
    bus.rs_val    = 32'd0;
    bus.rt_val    = 32'd0;
  endtask

  task drain;
    int n;
    n = 0;
    while (state != 2'd0 && n < 40) begin
      step;
      n++;
    end
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL drain_timeout: state %0d exp 0", state); end
  endtask

  task test_reset;
    idle_inputs;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
    #1;
    checks++; if (state !== 2'd0)        begin errors++; $display("FAIL reset_state: got %0d exp 0", state); end
    checks++; if (bus.Start !== 1'b0)    begin errors++; $display("FAIL reset_start: got %b exp 0", bus.Start); end
    checks++; if (bus.opsrc !== 3'd0)    begin errors++; $display("FAIL reset_opsrc: got %0d exp 0", bus.opsrc); end
    checks++; if (bus.wsrc !== 2'd0)     begin errors++; $display("FAIL reset_wsrc: got %0d exp 0", bus.wsrc); end
    checks++; if (bus.D1 !== 32'd0)      begin errors++; $display("FAIL reset_d1: got %h exp 0", bus.D1); end
    checks++; if (bus.D2 !== 32'd0)      begin errors++; $display("FAIL reset_d2: got %h exp 0", bus.D2); end
    checks++; if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b exp 0", bus.illegal_op); end
    checks++; if (bus.stall !== 1'b0)    begin errors++; $display("FAIL reset_stall: got %b exp 0", bus.stall); end
  endtask

  task test_mult;
    int n;
    busy_len = 5;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd1;
    bus.rs_val    = 32'd7;
    bus.rt_val    = 32'hFFFF_FFFD;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mult_accept_stall: got %b exp 1", bus.stall); end
    step;
    bus.req_op = 3'd0;
    bus.req_rd = 1'b1;
    #1;
    checks++; if (state !== 2'd1)            begin errors++; $display("FAIL mult_issue_state: got %0d exp 1", state); end
    checks++; if (bus.Start !== 1'b1)        begin errors++; $display("FAIL mult_start: got %b exp 1", bus.Start); end
    checks++; if (bus.opsrc !== 3'd1)        begin errors++; $display("FAIL mult_opsrc: got %0d exp 1", bus.opsrc); end
    checks++; if (bus.D1 !== 32'd7)          begin errors++; $display("FAIL mult_d1: got %h exp 7", bus.D1); end
    checks++; if (bus.D2 !== 32'hFFFF_FFFD)  begin errors++; $display("FAIL mult_d2: got %h exp fffffffd", bus.D2); end
    checks++; if (bus.stall !== 1'b1)        begin errors++; $display("FAIL mult_issue_stall: got %b exp 1", bus.stall); end
    step;
    n = 0;
    while (state == 2'd2 && n < 20) begin
      checks++; if (bus.Start !== 1'b0) begin errors++; $display("FAIL mult_wait_start: got %b exp 0", bus.Start); end
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mult_wait_stall: got %b exp 1", bus.stall); end
      n++;
      step;
    end
    checks++; if (n != 6)             begin errors++; $display("FAIL mult_wait_len: got %0d exp 6", n); end
    checks++; if (state !== 2'd0)     begin errors++; $display("FAIL mult_back_idle: got %0d exp 0", state); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mult_mflo_release: got %b exp 0", bus.stall); end
    idle_inputs;
    step;
  endtask

  task test_div_mflo;
    int n;
    int busy_stalls;
    int starts;
    busy_len = 10;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd3;
    bus.rs_val    = 32'd100;
    bus.rt_val    = 32'd7;
    step;
    bus.req_op = 3'd0;
    bus.req_rd = 1'b1;
    #1;
    checks++; if (bus.Start !== 1'b1) begin errors++; $display("FAIL div_start: got %b exp 1", bus.Start); end
    checks++; if (bus.opsrc !== 3'd3) begin errors++; $display("FAIL div_opsrc: got %0d exp 3", bus.opsrc); end
    step;
    n = 0; busy_stalls = 0; starts = 0;
    while (state == 2'd2 && n < 30) begin
      if (bus.md_busy && bus.stall) busy_stalls++;
      if (bus.Start) starts++;
      n++;
      step;
    end
    checks++; if (busy_stalls != 10) begin errors++; $display("FAIL div_busy_stall: got %0d exp 10", busy_stalls); end
    checks++; if (n != 11)           begin errors++; $display("FAIL div_wait_len: got %0d exp 11", n); end
    checks++; if (starts != 0)       begin errors++; $display("FAIL div_second_start: got %0d exp 0", starts); end
    checks++; if (state !== 2'd0)    begin errors++; $display("FAIL div_idle: got %0d exp 0", state); end
    idle_inputs;
    step;
  endtask

  task test_mthi;
    bus.req_valid = 1'b1;
    bus.req_wsrc  = 2'd1;
    bus.rs_val    = 32'h1234_5678;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mthi_stall: got %b exp 1", bus.stall); end
    step;
    idle_inputs;
    #1;
    checks++; if (state !== 2'd3)          begin errors++; $display("FAIL mthi_state: got %0d exp 3", state); end
    checks++; if (bus.wsrc !== 2'd1)       begin errors++; $display("FAIL mthi_wsrc: got %0d exp 1", bus.wsrc); end
    checks++; if (bus.D1 !== 32'h1234_5678) begin errors++; $display("FAIL mthi_d1: got %h exp 12345678", bus.D1); end
    checks++; if (bus.D2 !== 32'd7)        begin errors++; $display("FAIL mthi_d2_hold: got %h exp 7", bus.D2); end
    checks++; if (bus.Start !== 1'b0)      begin errors++; $display("FAIL mthi_start: got %b exp 0", bus.Start); end
    step;
    checks++; if (state !== 2'd0)    begin errors++; $display("FAIL mthi_idle: got %0d exp 0", state); end
    checks++; if (bus.wsrc !== 2'd0) begin errors++; $display("FAIL mthi_wsrc_clr: got %0d exp 0", bus.wsrc); end
  endtask

  task test_madd;
    busy_len = 3;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd5;
    bus.rs_val    = 32'd9;
    bus.rt_val    = 32'd4;
    #1;
`ifdef MD_MADD_EN
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL madd_stall: got %b exp 1", bus.stall); end
    step;
    idle_inputs;
    #1;
    checks++; if (bus.Start !== 1'b1) begin errors++; $display("FAIL madd_start: got %b exp 1", bus.Start); end
    checks++; if (bus.opsrc !== 3'd5) begin errors++; $display("FAIL madd_opsrc: got %0d exp 5", bus.opsrc); end
    drain;
`else
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL madd_ill_stall: got %b exp 0", bus.stall); end
    step;
    idle_inputs;
    #1;
    checks++; if (bus.illegal_op !== 1'b1) begin errors++; $display("FAIL madd_ill_flag: got %b exp 1", bus.illegal_op); end
    checks++; if (bus.Start !== 1'b0)      begin errors++; $display("FAIL madd_ill_start: got %b exp 0", bus.Start); end
    checks++; if (state !== 2'd0)          begin errors++; $display("FAIL madd_ill_state: got %0d exp 0", state); end
    step;
    checks++; if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL madd_ill_pulse: got %b exp 0", bus.illegal_op); end
`endif
  endtask

  task test_illegal;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd7;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL ill7_stall: got %b exp 0", bus.stall); end
    step;
    bus.req_op   = 3'd0;
    bus.req_wsrc = 2'd3;
    #1;
    checks++; if (bus.illegal_op !== 1'b1) begin errors++; $display("FAIL ill7_flag: got %b exp 1", bus.illegal_op); end
    checks++; if (state !== 2'd0)          begin errors++; $display("FAIL ill7_state: got %0d exp 0", state); end
    checks++; if (bus.stall !== 1'b0)      begin errors++; $display("FAIL ilw3_stall: got %b exp 0", bus.stall); end
    step;
    idle_inputs;
    #1;
    checks++; if (bus.illegal_op !== 1'b1) begin errors++; $display("FAIL ilw3_flag: got %b exp 1", bus.illegal_op); end
    checks++; if (bus.wsrc !== 2'd0)       begin errors++; $display("FAIL ilw3_wsrc: got %0d exp 0", bus.wsrc); end
    step;
    checks++; if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL ill_clear: got %b exp 0", bus.illegal_op); end
  endtask

  task test_reset_abort;
    busy_len = 5;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd2;
    bus.rs_val    = 32'd11;
    bus.rt_val    = 32'd13;
    step;
    idle_inputs;
    step;
    checks++; if (state !== 2'd2)     begin errors++; $display("FAIL abort_w1_state: got %0d exp 2", state); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL abort_novalid_stall: got %b exp 0", bus.stall); end
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    #1;
    checks++; if (state !== 2'd0)          begin errors++; $display("FAIL abort_state: got %0d exp 0", state); end
    checks++; if (bus.Start !== 1'b0)      begin errors++; $display("FAIL abort_start: got %b exp 0", bus.Start); end
    checks++; if (bus.opsrc !== 3'd0)      begin errors++; $display("FAIL abort_opsrc: got %0d exp 0", bus.opsrc); end
    checks++; if (bus.D1 !== 32'd0)        begin errors++; $display("FAIL abort_d1: got %h exp 0", bus.D1); end
    checks++; if (bus.D2 !== 32'd0)        begin errors++; $display("FAIL abort_d2: got %h exp 0", bus.D2); end
    checks++; if (bus.wsrc !== 2'd0)       begin errors++; $display("FAIL abort_wsrc: got %0d exp 0", bus.wsrc); end
    checks++; if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL abort_illegal: got %b exp 0", bus.illegal_op); end
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd4;
    bus.rs_val    = 32'd50;
    bus.rt_val    = 32'd5;
    step;
    idle_inputs;
    #1;
    checks++; if (state !== 2'd1)      begin errors++; $display("FAIL divu_state: got %0d exp 1", state); end
    checks++; if (bus.Start !== 1'b1)  begin errors++; $display("FAIL divu_start: got %b exp 1", bus.Start); end
    checks++; if (bus.opsrc !== 3'd4)  begin errors++; $display("FAIL divu_opsrc: got %0d exp 4", bus.opsrc); end
    checks++; if (bus.D1 !== 32'd50)   begin errors++; $display("FAIL divu_d1: got %h exp 32", bus.D1); end
    drain;
  endtask

  task test_priority;
    busy_len = 2;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd3;
    bus.req_wsrc  = 2'd2;
    bus.rs_val    = 32'd21;
    bus.rt_val    = 32'd3;
    step;
    idle_inputs;
    #1;
    checks++; if (state !== 2'd1)          begin errors++; $display("FAIL prio_state: got %0d exp 1", state); end
    checks++; if (bus.Start !== 1'b1)      begin errors++; $display("FAIL prio_start: got %b exp 1", bus.Start); end
    checks++; if (bus.opsrc !== 3'd3)      begin errors++; $display("FAIL prio_opsrc: got %0d exp 3", bus.opsrc); end
    checks++; if (bus.wsrc !== 2'd0)       begin errors++; $display("FAIL prio_wsrc: got %0d exp 0", bus.wsrc); end
    checks++; if (bus.illegal_op !== 1'b1) begin errors++; $display("FAIL prio_illegal: got %b exp 1", bus.illegal_op); end
    step;
    checks++; if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL prio_ill_pulse: got %b exp 0", bus.illegal_op); end
    checks++; if (bus.Start !== 1'b0)      begin errors++; $display("FAIL prio_start_pulse: got %b exp 0", bus.Start); end
    drain;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    busy_len = 5;
    rst      = 1'b1;
    idle_inputs;
    test_reset;
    test_mult;
    test_div_mflo;
    test_mthi;
    test_madd;
    test_illegal;
    test_reset_abort;
    test_priority;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
